// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Holds the FSM state encoding, the default width and the counter sizing.
package div_pkg;

    localparam int DIV_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width for a 2*size-bit dividend.
    function automatic int div_cnt_w(input int size);
        return $clog2(2 * size);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract.
// Compare and subtract are unsigned and size+1 bits wide.
module div_restore_step #(
    parameter int size = 8
) (
    input  logic [size:0]   i_rem,
    input  logic            i_msb,
    input  logic [size-1:0] i_divisor,
    output logic [size:0]   o_rem,
    output logic            o_qbit
);

    logic [size:0] w_p;
    logic [size:0] w_dsr;
    logic [size:0] w_diff;
    logic          w_ge;

    assign w_p    = {i_rem[size-1:0], i_msb};
    assign w_dsr  = {1'b0, i_divisor};
    assign w_diff = w_p - w_dsr;

    // A set top remainder bit means the shifted value overflowed the
    // trial width, so it is certainly not below the divisor.
    assign w_ge   = i_rem[size] | (w_p >= w_dsr);

    // Restore (keep p) or accept the subtraction.
    always_comb begin
        o_qbit = w_ge;
        o_rem  = w_ge ? w_diff : w_p;
    end

endmodule

// File: rtl/div_iter_16bit.sv
// Iterative restoring divider: 2*size-bit dividend by size-bit divisor.
// One operation in flight, fixed latency, one-cycle result strobe.
module div_iter_16bit
    import div_pkg::*;
#(
    parameter int size = DIV_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_en_in,
    input  logic [2*size-1:0] div_a,
    input  logic [size-1:0]   div_b,
    output logic              div_busy,
    output logic              div_en_out,
    output logic [2*size-1:0] div_quo,
    output logic [size-1:0]   div_rem,
    output logic              div_by_zero
);

    localparam int DW = 2 * size;
    localparam int CW = div_cnt_w(size);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_t      r_state;
    div_state_t      w_next;

    logic [DW-1:0]   r_dvd;
    logic [size-1:0] r_dsr;
    logic [size:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_zero;

    logic [DW-1:0]   r_quo;
    logic [size-1:0] r_remo;
    logic            r_dbz;
    logic            r_en_out;

    logic            w_busy;
    logic            w_load;
    logic            w_step;
    logic            w_done;
    logic [size:0]   w_rem_nxt;
    logic            w_qbit;

    div_restore_step #(
        .size      (size)
    ) u_step (
        .i_rem     (r_rem),
        .i_msb     (r_dvd[DW-1]),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: accept in IDLE, leave CALC on the last step, DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (div_en_in) w_next = CALC;
            CALC:    if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control decode from the registered state.
    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: w_load = div_en_in;
            CALC: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // Datapath: capture operands on accept, then one restoring step per cycle.
    // The dividend register doubles as the quotient register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (w_load) begin
            r_dvd  <= div_a;
            r_dsr  <= div_b;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_zero <= (div_b == '0);
        end else if (w_step) begin
            r_dvd  <= {r_dvd[DW-2:0], w_qbit};
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Result registers: load once per operation, hold until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo    <= '0;
            r_remo   <= '0;
            r_dbz    <= 1'b0;
            r_en_out <= 1'b0;
        end else begin
            r_en_out <= w_done;
            if (w_done) begin
                r_quo  <= r_zero ? '1 : r_dvd;
                r_remo <= r_zero ? '0 : r_rem[size-1:0];
                r_dbz  <= r_zero;
            end
        end
    end

    assign div_busy    = w_busy;
    assign div_en_out  = r_en_out;
    assign div_quo     = r_quo;
    assign div_rem     = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter_16bit.sv
// Bench for div_iter_16bit: directed steps, scoreboard queue of expected results.
// Latency and operation spacing are modelled independently of the DUT.
module tb_div_iter_16bit;

    localparam int SZ  = 8;
    localparam int LAT = 18;

    typedef struct {
        logic [15:0] quo;
        logic [7:0]  rem;
        logic        dbz;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        div_en_in;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic        div_busy;
    logic        div_en_out;
    logic [15:0] div_quo;
    logic [7:0]  div_rem;
    logic        div_by_zero;

    exp_t q[$];
    exp_t m_e;
    int   cyc;
    int   free_at;
    int   npulse;
    int   npass;
    int   ntot;
    int   p0;
    int   nacc;

    div_iter_16bit #(
        .size        (SZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_en_in   (div_en_in),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_busy    (div_busy),
        .div_en_out  (div_en_out),
        .div_quo     (div_quo),
        .div_rem     (div_rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.quo = 16'hFFFF;
            e.rem = 8'd0;
            e.dbz = 1'b1;
        end else begin
            e.quo = a / {8'd0, b};
            e.rem = 8'(a % {8'd0, b});
            e.dbz = 1'b0;
        end
        e.due = cyc + LAT;
        q.push_back(e);
        free_at = cyc + LAT;
        nacc++;
    endtask

    task automatic req(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        div_a     = a;
        div_b     = b;
        div_en_in = 1'b1;
        if (cyc >= free_at) push(a, b);
        @(negedge clk);
        div_en_in = 1'b0;
        chk("busy_after_req", {31'd0, div_busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 32'd0);
        chk("idle_busy", {31'd0, div_busy}, 32'd0);
    endtask

    // Result monitor: pop and compare on each strobe, flag missing strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_en_out) begin
                npulse++;
                if (q.size() == 0) begin
                    chk("spurious_pulse", {31'd0, div_en_out}, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("quo", {16'd0, div_quo}, {16'd0, m_e.quo});
                    chk("rem", {24'd0, div_rem}, {24'd0, m_e.rem});
                    chk("dbz", {31'd0, div_by_zero}, {31'd0, m_e.dbz});
                    chk("latency", cyc, m_e.due);
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                chk("missing_pulse", {31'd0, div_en_out}, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        cyc       = 0;
        free_at   = 0;
        npulse    = 0;
        npass     = 0;
        ntot      = 0;
        nacc      = 0;
        rst_n     = 1'b0;
        div_en_in = 1'b0;
        div_a     = '0;
        div_b     = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, div_busy}, 32'd0);
        chk("rst_en_out", {31'd0, div_en_out}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_quo", {16'd0, div_quo}, 32'd0);
        chk("rst_rem", {24'd0, div_rem}, 32'd0);
        rst_n = 1'b1;

        req(16'd100, 8'd7);
        wait_done();
        req(16'd65025, 8'd255);
        wait_done();
        req(16'd65535, 8'd255);
        wait_done();
        req(16'd1234, 8'd0);
        wait_done();
        req(16'd9, 8'd3);
        wait_done();

        p0 = npulse;
        req(16'd100, 8'd7);
        repeat (3) @(negedge clk);
        req(16'd50, 8'd5);
        wait_done();
        repeat (20) @(negedge clk);
        chk("one_pulse", npulse - p0, 32'd1);
        chk("hold_quo", {16'd0, div_quo}, 32'd14);
        chk("hold_rem", {24'd0, div_rem}, 32'd2);

        req(16'd200, 8'd3);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        free_at = 0;
        chk("abort_busy", {31'd0, div_busy}, 32'd0);
        chk("abort_en_out", {31'd0, div_en_out}, 32'd0);
        chk("abort_quo", {16'd0, div_quo}, 32'd0);
        chk("abort_rem", {24'd0, div_rem}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = npulse;
        repeat (40) @(negedge clk);
        chk("no_pulse_after_rst", npulse - p0, 32'd0);

        p0   = npulse;
        nacc = 0;
        for (int k = 0; k < 5 * LAT; k++) begin
            @(negedge clk);
            div_a     = 16'($urandom);
            div_b     = 8'($urandom_range(0, 255));
            div_en_in = 1'b1;
            if (cyc >= free_at) push(div_a, div_b);
        end
        @(negedge clk);
        div_en_in = 1'b0;
        wait_done();
        chk("b2b_count", npulse - p0, nacc);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
